bpsk_tx: RTL

Transmit-side counterpart of the PSK correlator chain. Accepts bytes over a valid/ready handshake and frames them as preamble plus data bits, LSB first. Produces a 1-bit BPSK line signal: an NCO square-wave carrier XORed with the (optionally differentially encoded) current chip. Drives the same link the correlator/NCO receiver listens to, using the same 13-bit phase/control-word convention.

---
 rtl/psk_pkg.sv | 14 +
 rtl/psk_phase_acc.sv | 31 +++
 rtl/bpsk_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/psk_pkg.sv
// psk_pkg: definitions shared by the PSK transmit and receive blocks.
//   PHASE_W_DEF : default phase accumulator width (13-bit control word)
//   BYTE_W      : width of the byte interface
//   tx_state_e  : transmitter frame state
package psk_pkg;
   localparam int PHASE_W_DEF = 13;
   localparam int BYTE_W      = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2
   } tx_state_e;
endpackage

// File: rtl/psk_phase_acc.sv
// psk_phase_acc: free-running phase accumulator (NCO core).
// The accumulator advances by control_word every clk and wraps mod 2^PHASE_W.
// Its MSB is the square-wave carrier.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears the phase)
//   control_word : phase increment per clk
//   carrier_nxt  : MSB of the value being loaded at the next edge, so that a
//                  consumer can register carrier-derived outputs in step with acc
module psk_phase_acc
   import psk_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PHASE_W-1:0] control_word,
   output logic               carrier_nxt
);

   logic [PHASE_W-1:0] acc;
   logic [PHASE_W-1:0] acc_nxt;

   assign acc_nxt     = acc + control_word;
   assign carrier_nxt = acc_nxt[PHASE_W-1];

   always_ff @(posedge clk) begin
      if (rst) acc <= '0;
      else     acc <= acc_nxt;
   end

endmodule

// File: rtl/bpsk_tx.sv
// bpsk_tx: byte-framed BPSK transmitter.
// Bytes arrive on a valid/ready handshake and go out as PREAMBLE_BITS zero
// symbols followed by data bits LSB first. Each symbol lasts sym_period clks
// (latched at frame start, 0 treated as 1). The line is the NCO carrier XORed
// with the chip, where the chip is either the bit (DIFF_ENC=0) or the running
// XOR of all bits of the frame so far (DIFF_ENC=1).
// Ports:
//   clk, rst       : clock, synchronous active-high reset (aborts any frame)
//   control_word   : carrier phase increment per clk
//   sym_period     : clks per symbol, sampled on frame start
//   tx_data/valid  : byte input; tx_ready accepts it
//   tx_out         : registered BPSK line output, 0 outside a frame
//   tx_en          : registered, high while a frame symbol is on tx_out
//   busy           : high whenever the FSM is not IDLE
module bpsk_tx
   import psk_pkg::*;
#(
   parameter int PHASE_W       = PHASE_W_DEF,
   parameter int SYM_W         = 16,
   parameter int PREAMBLE_BITS = 16,
   parameter bit DIFF_ENC      = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PHASE_W-1:0] control_word,
   input  logic [SYM_W-1:0]   sym_period,
   input  logic [BYTE_W-1:0]  tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic               tx_out,
   output logic               tx_en,
   output logic               busy
);

   // idx counts preamble symbols in PREAMBLE and the bit position in DATA.
   localparam int IDX_MAX = (PREAMBLE_BITS > BYTE_W) ? PREAMBLE_BITS : BYTE_W;
   localparam int IDX_W   = $clog2(IDX_MAX);
   localparam logic [IDX_W-1:0] PRE_LAST =
      IDX_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);

   tx_state_e          state, state_n;
   logic [SYM_W-1:0]   sym_cnt, sym_cnt_n;
   logic [SYM_W-1:0]   period_q, period_n;
   logic [IDX_W-1:0]   idx, idx_n;
   logic [BYTE_W-1:0]  byte_q, byte_n;
   logic               chip, chip_n;
   logic               ready_n;
   logic               carrier_nxt;

   logic               accept, sym_end, new_sym, bit_n, chip_base;

   psk_phase_acc #(.PHASE_W(PHASE_W)) u_acc (
      .clk          (clk),
      .rst          (rst),
      .control_word (control_word),
      .carrier_nxt  (carrier_nxt)
   );

   assign busy    = (state != IDLE);
   assign accept  = tx_valid & tx_ready;
   assign sym_end = (sym_cnt == period_q - SYM_W'(1));

   always_comb begin
      state_n   = state;
      sym_cnt_n = sym_cnt;
      period_n  = period_q;
      idx_n     = idx;
      byte_n    = byte_q;
      chip_n    = chip;
      new_sym   = 1'b0;
      bit_n     = 1'b0;
      chip_base = chip;

      case (state)
         IDLE: begin
            if (accept) begin
               byte_n    = tx_data;
               period_n  = (sym_period == '0) ? SYM_W'(1) : sym_period;
               sym_cnt_n = '0;
               idx_n     = '0;
               new_sym   = 1'b1;
               chip_base = 1'b0;            // differential state restarts per frame
               if (PREAMBLE_BITS == 0) begin
                  state_n = DATA;
                  bit_n   = tx_data[0];
               end else begin
                  state_n = PREAMBLE;
               end
            end
         end

         PREAMBLE: begin
            if (sym_end) begin
               sym_cnt_n = '0;
               new_sym   = 1'b1;
               if (idx == PRE_LAST) begin
                  state_n = DATA;
                  idx_n   = '0;
                  bit_n   = byte_q[0];
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end else begin
               sym_cnt_n = sym_cnt + SYM_W'(1);
            end
         end

         DATA: begin
            if (sym_end) begin
               sym_cnt_n = '0;
               if (idx[2:0] == 3'd7) begin
                  // Back-to-back byte: keep period and chip state, no preamble.
                  if (accept) begin
                     byte_n  = tx_data;
                     idx_n   = '0;
                     new_sym = 1'b1;
                     bit_n   = tx_data[0];
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  idx_n   = idx + IDX_W'(1);
                  new_sym = 1'b1;
                  bit_n   = byte_q[idx[2:0] + 3'd1];
               end
            end else begin
               sym_cnt_n = sym_cnt + SYM_W'(1);
            end
         end

         default: state_n = IDLE;
      endcase

      if (new_sym)
         chip_n = DIFF_ENC ? (chip_base ^ bit_n) : bit_n;

      // Ready is registered: it is decoded from the state the next cycle will hold.
      ready_n = (state_n == IDLE) ||
                ((state_n == DATA) && (idx_n[2:0] == 3'd7) &&
                 (sym_cnt_n == period_n - SYM_W'(1)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sym_cnt  <= '0;
         period_q <= SYM_W'(1);
         idx      <= '0;
         byte_q   <= '0;
         chip     <= 1'b0;
         tx_ready <= 1'b0;
         tx_en    <= 1'b0;
         tx_out   <= 1'b0;
      end else begin
         state    <= state_n;
         sym_cnt  <= sym_cnt_n;
         period_q <= period_n;
         idx      <= idx_n;
         byte_q   <= byte_n;
         chip     <= chip_n;
         tx_ready <= ready_n;
         tx_en    <= (state_n != IDLE);
         tx_out   <= (state_n != IDLE) & (carrier_nxt ^ chip_n);
      end
   end

endmodule
